// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time-keeping core.
//   swState_e  : operating mode encoding (RUN / PAUSED / ADJUST)
//   selField_e : adjust field select encoding (minutes / seconds)
//   DigitW     : width of one BCD digit
//   SecLim*    : seconds limit (59) as a BCD pair
//   bcdPair()  : converts a 0..99 integer into {tens, ones} BCD

package stopwatch_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StPaused = 2'b01,
        StAdjust = 2'b10
    } swState_e;

    typedef enum logic {
        SelMin = 1'b0,
        SelSec = 1'b1
    } selField_e;

    localparam int unsigned DigitW = 4;

    localparam logic [DigitW-1:0] SecLimTens = 4'd5;
    localparam logic [DigitW-1:0] SecLimOnes = 4'd9;

    function automatic logic [2*DigitW-1:0] bcdPair(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter.
//   clkDis  : clock
//   rstN    : synchronous active-low reset, clears to 00
//   clr     : functional clear to 00 (beats inc)
//   inc     : advance by one; wraps to 00 after the limit
//   limTens : tens digit of the limit value
//   limOnes : ones digit of the limit value
//   tens    : registered tens digit
//   ones    : registered ones digit
//   wrap    : combinational; high when this cycle's inc takes the count from limit to 00

module bcd_mod_counter
    import stopwatch_pkg::*;
(
    input  logic              clkDis,
    input  logic              rstN,
    input  logic              clr,
    input  logic              inc,
    input  logic [DigitW-1:0] limTens,
    input  logic [DigitW-1:0] limOnes,
    output logic [DigitW-1:0] tens,
    output logic [DigitW-1:0] ones,
    output logic              wrap
);

    logic atLimit;

    assign atLimit = (tens == limTens) && (ones == limOnes);
    assign wrap    = inc && atLimit;

    always_ff @(posedge clkDis) begin
        if (!rstN) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (atLimit) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == 4'd9) begin
                ones <= '0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: MM:SS as four BCD digits with run, paused and adjust modes.
//   clkDis     : clock (all inputs synchronous to it)
//   rstN       : synchronous active-low reset
//   rstPulse   : one-cycle functional clear of the count (mode kept)
//   pausePulse : one-cycle run/pause toggle
//   tick1Hz    : one-cycle count enable, once per second
//   tick2Hz    : one-cycle adjust enable, twice per second
//   adj        : adjust mode switch (level)
//   sel        : adjust field select, 0 = minutes, 1 = seconds
//   minTens, minOnes, secTens, secOnes : BCD digits
//   paused     : saved mode (resume) is PAUSED
//   adjusting  : in ADJUST
//   rollover   : one-cycle pulse after the count wraps MAX_MIN:59 -> 00:00 in RUN

module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic              clkDis,
    input  logic              rstN,
    input  logic              rstPulse,
    input  logic              pausePulse,
    input  logic              tick1Hz,
    input  logic              tick2Hz,
    input  logic              adj,
    input  logic              sel,
    output logic [DigitW-1:0] minTens,
    output logic [DigitW-1:0] minOnes,
    output logic [DigitW-1:0] secTens,
    output logic [DigitW-1:0] secOnes,
    output logic              paused,
    output logic              adjusting,
    output logic              rollover
);

    localparam logic [2*DigitW-1:0] MinLim = bcdPair(MAX_MIN);

    swState_e stateQ;
    swState_e resumeQ;

    logic runTick;
    logic adjTick;
    logic secInc;
    logic minInc;
    logic secWrap;
    logic minWrap;
    logic rolloverD;

    // Mode decisions always look at the current-state register, so a tick that
    // coincides with a mode change is judged by the mode it arrived in.
    assign runTick = (stateQ == StRun) && tick1Hz;
    assign adjTick = (stateQ == StAdjust) && tick2Hz;

    // In ADJUST each field wraps on its own; the seconds wrap only carries in RUN.
    assign secInc = runTick || (adjTick && (sel == SelSec));
    assign minInc = (runTick && secWrap) || (adjTick && (sel == SelMin));

    assign rolloverD = runTick && secWrap && minWrap && !rstPulse;

    bcd_mod_counter u_sec (
        .clkDis  (clkDis),
        .rstN    (rstN),
        .clr     (rstPulse),
        .inc     (secInc),
        .limTens (SecLimTens),
        .limOnes (SecLimOnes),
        .tens    (secTens),
        .ones    (secOnes),
        .wrap    (secWrap)
    );

    bcd_mod_counter u_min (
        .clkDis  (clkDis),
        .rstN    (rstN),
        .clr     (rstPulse),
        .inc     (minInc),
        .limTens (MinLim[2*DigitW-1:DigitW]),
        .limOnes (MinLim[DigitW-1:0]),
        .tens    (minTens),
        .ones    (minOnes),
        .wrap    (minWrap)
    );

    always_ff @(posedge clkDis) begin
        if (!rstN) begin
            stateQ   <= StRun;
            resumeQ  <= StRun;
            rollover <= 1'b0;
        end else begin
            rollover <= rolloverD;
            // rstPulse clears the count only; mode and resume are frozen that cycle.
            if (!rstPulse) begin
                // Outside ADJUST resume always equals the state, so toggling it
                // here both tracks RUN/PAUSED and edits the saved mode in ADJUST.
                if (pausePulse) begin
                    resumeQ <= (resumeQ == StPaused) ? StRun : StPaused;
                end
                if (adj) begin
                    stateQ <= StAdjust;
                end else begin
                    case (stateQ)
                        StRun:    if (pausePulse) stateQ <= StPaused;
                        StPaused: if (pausePulse) stateQ <= StRun;
                        StAdjust: stateQ <= resumeQ;
                        default:  stateQ <= StRun;
                    endcase
                end
            end
        end
    end

    assign paused    = (resumeQ == StPaused);
    assign adjusting = (stateQ == StAdjust);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: each driven cycle pushes the expected
// digits/flags from a decimal MM:SS model, popped and compared one cycle later.

module tb_stopwatch_counter;

    localparam int unsigned MaxMin = 59;
    localparam int MRun = 0;
    localparam int MPaused = 1;
    localparam int MAdj = 2;

    logic       clkDis = 1'b0;
    logic       rstN = 1'b0;
    logic       rstPulse = 1'b0;
    logic       pausePulse = 1'b0;
    logic       tick1Hz = 1'b0;
    logic       tick2Hz = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] minTens, minOnes, secTens, secOnes;
    logic       paused, adjusting, rollover;

    typedef struct {
        string       tag;
        logic [15:0] digits;
        logic [2:0]  flags;
    } expEntry_t;

    expEntry_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int mm = 0;
    int ss = 0;
    int mode = MRun;
    bit resP = 1'b0;
    bit rollE = 1'b0;

    stopwatch_counter #(
        .MAX_MIN (MaxMin)
    ) dut (
        .clkDis     (clkDis),
        .rstN       (rstN),
        .rstPulse   (rstPulse),
        .pausePulse (pausePulse),
        .tick1Hz    (tick1Hz),
        .tick2Hz    (tick2Hz),
        .adj        (adj),
        .sel        (sel),
        .minTens    (minTens),
        .minOnes    (minOnes),
        .secTens    (secTens),
        .secOnes    (secOnes),
        .paused     (paused),
        .adjusting  (adjusting),
        .rollover   (rollover)
    );

    always #5 clkDis = ~clkDis;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] modelDigits();
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dutDigits();
        return {minTens, minOnes, secTens, secOnes};
    endfunction

    task automatic pushExp(input string tag);
        expEntry_t e;
        e.tag    = tag;
        e.digits = modelDigits();
        e.flags  = {resP, (mode == MAdj), rollE};
        sb.push_back(e);
    endtask

    task automatic popCheck();
        expEntry_t e;
        if (sb.size() == 0) begin
            checkVal("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkVal({e.tag, ".digits"}, {16'd0, dutDigits()}, {16'd0, e.digits});
            checkVal({e.tag, ".flags"}, {29'd0, paused, adjusting, rollover}, {29'd0, e.flags});
        end
    endtask

    // One clock cycle of stimulus: drive on the falling edge, model the next
    // state, then compare one step after the rising edge.
    task automatic step(input string tag, input bit rp, input bit pp, input bit t1,
                        input bit t2, input bit a, input bit s);
        int  oldMode;
        bit  oldRes;
        @(negedge clkDis);
        rstPulse   = rp;
        pausePulse = pp;
        tick1Hz    = t1;
        tick2Hz    = t2;
        adj        = a;
        sel        = s;
        oldMode = mode;
        oldRes  = resP;
        rollE   = 1'b0;
        if (rp) begin
            mm = 0;
            ss = 0;
        end else begin
            if (oldMode == MRun && t1) begin
                ss++;
                if (ss == 60) begin
                    ss = 0;
                    mm++;
                    if (mm == MaxMin + 1) begin
                        mm    = 0;
                        rollE = 1'b1;
                    end
                end
            end else if (oldMode == MAdj && t2) begin
                if (s) ss = (ss + 1) % 60;
                else   mm = (mm + 1) % (MaxMin + 1);
            end
            if (pp) resP = !resP;
            if (a)                    mode = MAdj;
            else if (oldMode == MAdj) mode = oldRes ? MPaused : MRun;
            else if (pp)              mode = (oldMode == MRun) ? MPaused : MRun;
        end
        pushExp(tag);
        @(posedge clkDis);
        #1;
        popCheck();
    endtask

    task automatic repeatStep(input string tag, input int n, input bit pp, input bit t1,
                              input bit t2, input bit a, input bit s);
        for (int i = 0; i < n; i++) step(tag, 1'b0, pp, t1, t2, a, s);
    endtask

    task automatic doReset(input string tag, input bit a);
        @(negedge clkDis);
        rstN       = 1'b0;
        rstPulse   = 1'b0;
        pausePulse = 1'b0;
        tick1Hz    = 1'b1;
        tick2Hz    = 1'b1;
        adj        = a;
        sel        = 1'b0;
        mm    = 0;
        ss    = 0;
        mode  = MRun;
        resP  = 1'b0;
        rollE = 1'b0;
        pushExp(tag);
        @(posedge clkDis);
        #1;
        popCheck();
        rstN = 1'b1;
    endtask

    // Adjust an already-cleared count up to mmT:ssT, then leave ADJUST.
    task automatic setTime(input int mmT, input int ssT);
        step("set_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("set_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeatStep("set_min", mmT, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeatStep("set_sec", ssT, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("set_exit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        doReset("reset", 1'b0);
        checkVal("reset_digits", {16'd0, dutDigits()}, 32'h0000);

        // 61 one-second ticks with idle cycles in between
        for (int i = 0; i < 61; i++) begin
            step("run_tick", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step("run_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkVal("count_01_01", {16'd0, dutDigits()}, 32'h0101);

        // Wrap from 58:59 through 59:59 to 00:00
        setTime(58, 59);
        repeatStep("wrap_tick", 60, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("wrap_last", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("wrap_rollover", {31'd0, rollover}, 32'd1);
        step("wrap_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pause holds the count, resume counts again
        step("pause_on", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeatStep("paused_tick", 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("pause_off", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeatStep("resumed_tick", 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Seconds adjust wraps without touching minutes
        setTime(7, 58);
        step("adj_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeatStep("adj_sec", 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkVal("adj_sec_07_01", {16'd0, dutDigits()}, 32'h0701);
        repeatStep("adj_min_wrap", 53, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("adj_exit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Functional clear coincident with a tick
        setTime(12, 34);
        step("rst_tick", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("rst_tick_digits", {16'd0, dutDigits()}, 32'h0000);
        setTime(59, 59);
        step("rst_at_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("rst_at_wrap_roll", {31'd0, rollover}, 32'd0);

        // Paused -> ADJUST, toggle saved mode, exit to RUN
        step("p_pause", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("p_adj", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("p_adj_pp", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("p_exit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("p_exit_paused", {31'd0, paused}, 32'd0);
        step("p_tick", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Same-cycle corner cases
        step("run_pp_tick", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("pau_pp_tick", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("run_adj_tick", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("adj_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        doReset("reset_mid_adj", 1'b1);
        step("adj_reenter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("adj_leave", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random mix
        for (int i = 0; i < 400; i++) begin
            bit rp, pp, t1, t2, a, s;
            rp = ($urandom_range(0, 39) == 0);
            pp = ($urandom_range(0, 15) == 0);
            t1 = ($urandom_range(0, 1) == 0);
            t2 = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 29) == 0) ? !adj : adj;
            s  = $urandom_range(0, 1) == 1;
            step("rand", rp, pp, t1, t2, a, s);
        end

        checkVal("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
